wb_dual_stage: RTL
==================

Name: wb_dual_stage

Overview:
Write-back stage for the dual-issue core. It sits directly downstream of the two EXM lanes and consumes their registered es_to_ws bundles. It retires lane 0 (older) and lane 1 (younger) in program order, drives two GPR write ports and one CSR write port, and returns per-lane forward buses to EXM. It serialises a dual CSR write over two cycles by back-pressuring EXM through ws_ready, and counts retired instructions.

Parameters:
ES_TO_WS_BUS_WD, 117, width of {csr_wen, csr_addr[13:0], csr_wdata[31:0], gr_we, dest[4:0], result[31:0], pc[31:0]}.
FORWARD_BUS_WD, 86, width of {valid, csr_wen, csr_addr, csr_wdata, gr_we, dest, result}.
CNT_WD, 64, width of the retire counter.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
ws_ready  out  1  1 = EXM may advance its output registers this cycle.
es0_to_ws_valid  in  2  lane 0: [0] instruction present, [1] lane complete.
es0_to_ws_bus  in  117  lane 0 bundle, field order as in ES_TO_WS_BUS_WD.
es1_to_ws_valid  in  2  lane 1, same encoding.
es1_to_ws_bus  in  117  lane 1 bundle.
rf_we0 / rf_waddr0 / rf_wdata0  out  1/5/32  GPR write port 0 (lane 0).
rf_we1 / rf_waddr1 / rf_wdata1  out  1/5/32  GPR write port 1 (lane 1).
csr_we / csr_waddr / csr_wdata  out  1/14/32  single CSR write port.
forward_data1  out  86  lane 0 forward bus: [85] valid, [84] csr_wen, [83:70] csr_addr, [69:38] csr_wdata, [37] gr_we, [36:32] dest, [31:0] result.
forward_data2  out  86  lane 1 forward bus, same layout.
retire_cnt  out  64  number of instructions retired since reset.

Behaviour:
- Commit condition: commitN = esN_to_ws_valid[0] & esN_to_ws_valid[1].
- States: IDLE and CSR2.
- Reset (asynchronous) values:
  - state = IDLE, retire_cnt = 0, pending CSR registers = 0.
  - All write enables 0. ws_ready = 1. forward valid bits 0 while reset is asserted.
- IDLE, GPR writes:
  - rf_weN = commitN & gr_weN & (destN != 0); address and data come from the bundle.
  - Same-destination conflict: both lanes write the same nonzero dest in the same cycle → rf_we0 is forced to 0. The younger lane 1 value wins.
- IDLE, CSR writes:
  - Exactly one committing lane has csr_wen → csr_we = 1 with that lane's addr and data. ws_ready = 1.
  - Both committing lanes have csr_wen:
    - Lane 0 CSR is written this cycle.
    - Lane 1 addr and data are captured into pending registers.
    - ws_ready = 0 (combinational). Next state = CSR2.
- IDLE retire counting: retire_cnt += commit0 + commit1 (adds 0, 1 or 2) on each clock edge.
- CSR2:
  - csr_we = 1 with the pending addr and data.
  - GPR writes are suppressed and retire_cnt does not change; they were already done in IDLE and EXM is holding the same bus.
  - ws_ready = 1. Next state = IDLE.
- Forward buses: combinational from the inputs, with valid = commitN. In CSR2, forward_data1 reports csr_wen = 0 and forward_data2 reports the pending CSR.
- Lanes with valid[0] = 1 and valid[1] = 0 do not commit: no write, no count, forward valid = 0.
- Reset in CSR2: the pending CSR write is discarded and state returns to IDLE.
- Latency: a committing bundle is written to the register file or CSR in the same cycle it is presented. The second CSR of a pair is written one cycle later.

Test Plan:
- Single GPR commit: lane 0 valid = 2'b11, gr_we = 1, dest = 5, result = 0x1234, lane 1 invalid → rf_we0 = 1, rf_waddr0 = 5, rf_wdata0 = 0x1234; retire_cnt goes 0→1; forward_data1[85] = 1.
- Write to r0: lane 1 commits with dest = 0, gr_we = 1 → rf_we1 = 0; retire_cnt still increments.
- Same-dest conflict: both lanes commit dest = 7, lane 0 result = 0xA, lane 1 result = 0xB → rf_we0 = 0, rf_we1 = 1 with data 0xB; retire_cnt increases by 2.
- Dual CSR: both lanes commit csr_wen, lane 0 addr 0x005 data 0x1, lane 1 addr 0x006 data 0x2 →
  - cycle N: csr_we = 1, addr 0x005, data 0x1, ws_ready = 0.
  - cycle N+1 (bus held): csr_we = 1, addr 0x006, data 0x2, ws_ready = 1, no GPR writes.
  - retire_cnt increases by exactly 2.
- Incomplete lane: valid = 2'b01 on both lanes → no writes, ws_ready = 1, retire_cnt unchanged, forward valid bits 0.
- Asynchronous reset asserted in CSR2 mid-cycle → the next write is not performed; after release state = IDLE, retire_cnt = 0, ws_ready = 1.

Source files
------------

// File: rtl/wb_dual_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_dual_stage
// Purpose  : Dual-lane write-back stage. Retires lane 0 then lane 1, drives two
//            GPR write ports and one CSR port, and splits a CSR pair over two cycles.
// Revision : 1.0 - initial release
// ============================================================================
module wb_dual_stage #(
    parameter int ES_TO_WS_BUS_WD = 117,
    parameter int FORWARD_BUS_WD  = 86,
    parameter int CNT_WD          = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ws_ready,
    input  logic [1:0]                 es0_to_ws_valid,
    input  logic [ES_TO_WS_BUS_WD-1:0] es0_to_ws_bus,
    input  logic [1:0]                 es1_to_ws_valid,
    input  logic [ES_TO_WS_BUS_WD-1:0] es1_to_ws_bus,
    output logic                       rf_we0,
    output logic [4:0]                 rf_waddr0,
    output logic [31:0]                rf_wdata0,
    output logic                       rf_we1,
    output logic [4:0]                 rf_waddr1,
    output logic [31:0]                rf_wdata1,
    output logic                       csr_we,
    output logic [13:0]                csr_waddr,
    output logic [31:0]                csr_wdata,
    output logic [FORWARD_BUS_WD-1:0]  forward_data1,
    output logic [FORWARD_BUS_WD-1:0]  forward_data2,
    output logic [CNT_WD-1:0]          retire_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CSR2 = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [13:0]       pend_addr_q, pend_addr_d;
    logic [31:0]       pend_data_q, pend_data_d;
    logic [CNT_WD-1:0] retire_cnt_q, retire_cnt_d;

    // Bundle fields (the pc field is carried for debug only and not consumed here)
    logic        w_csr_wen0, w_csr_wen1, w_gr_we0, w_gr_we1;
    logic [13:0] w_csr_addr0, w_csr_addr1;
    logic [31:0] w_csr_wdata0, w_csr_wdata1, w_result0, w_result1;
    logic [4:0]  w_dest0, w_dest1;

    assign w_csr_wen0   = es0_to_ws_bus[116];
    assign w_csr_addr0  = es0_to_ws_bus[115:102];
    assign w_csr_wdata0 = es0_to_ws_bus[101:70];
    assign w_gr_we0     = es0_to_ws_bus[69];
    assign w_dest0      = es0_to_ws_bus[68:64];
    assign w_result0    = es0_to_ws_bus[63:32];

    assign w_csr_wen1   = es1_to_ws_bus[116];
    assign w_csr_addr1  = es1_to_ws_bus[115:102];
    assign w_csr_wdata1 = es1_to_ws_bus[101:70];
    assign w_gr_we1     = es1_to_ws_bus[69];
    assign w_dest1      = es1_to_ws_bus[68:64];
    assign w_result1    = es1_to_ws_bus[63:32];

    logic w_commit0, w_commit1, w_gr0, w_gr1, w_conflict, w_csr0, w_csr1;

    assign w_commit0  = es0_to_ws_valid[0] & es0_to_ws_valid[1];
    assign w_commit1  = es1_to_ws_valid[0] & es1_to_ws_valid[1];
    assign w_gr0      = w_commit0 & w_gr_we0 & (w_dest0 != 5'd0);
    assign w_gr1      = w_commit1 & w_gr_we1 & (w_dest1 != 5'd0);
    // Younger lane wins a same-register collision
    assign w_conflict = w_gr0 & w_gr1 & (w_dest0 == w_dest1);
    assign w_csr0     = w_commit0 & w_csr_wen0;
    assign w_csr1     = w_commit1 & w_csr_wen1;

    assign rf_waddr0  = w_dest0;
    assign rf_wdata0  = w_result0;
    assign rf_waddr1  = w_dest1;
    assign rf_wdata1  = w_result1;
    assign retire_cnt = retire_cnt_q;

    always_comb begin
        state_d      = state_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        retire_cnt_d = retire_cnt_q;
        rf_we0       = 1'b0;
        rf_we1       = 1'b0;
        csr_we       = 1'b0;
        csr_waddr    = w_csr_addr0;
        csr_wdata    = w_csr_wdata0;
        ws_ready     = 1'b1;

        case (state_q)
            IDLE: begin
                rf_we0       = w_gr0 & ~w_conflict;
                rf_we1       = w_gr1;
                retire_cnt_d = retire_cnt_q + {{(CNT_WD-1){1'b0}}, w_commit0}
                                            + {{(CNT_WD-1){1'b0}}, w_commit1};
                if (w_csr0 && w_csr1) begin
                    csr_we      = 1'b1;
                    pend_addr_d = w_csr_addr1;
                    pend_data_d = w_csr_wdata1;
                    ws_ready    = 1'b0;
                    state_d     = CSR2;
                end else if (w_csr0) begin
                    csr_we = 1'b1;
                end else if (w_csr1) begin
                    csr_we    = 1'b1;
                    csr_waddr = w_csr_addr1;
                    csr_wdata = w_csr_wdata1;
                end
            end
            CSR2: begin
                // EXM is still presenting the pair; only the deferred CSR is written
                csr_we    = 1'b1;
                csr_waddr = pend_addr_q;
                csr_wdata = pend_data_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            rf_we0   = 1'b0;
            rf_we1   = 1'b0;
            csr_we   = 1'b0;
            ws_ready = 1'b1;
        end
    end

    always_comb begin
        forward_data1 = {w_commit0 & ~reset, w_csr_wen0 & (state_q == IDLE),
                         w_csr_addr0, w_csr_wdata0, w_gr_we0, w_dest0, w_result0};
        forward_data2 = {w_commit1 & ~reset, w_csr_wen1,
                         w_csr_addr1, w_csr_wdata1, w_gr_we1, w_dest1, w_result1};
        if (state_q == CSR2) begin
            forward_data2[84]    = 1'b1;
            forward_data2[83:70] = pend_addr_q;
            forward_data2[69:38] = pend_data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

endmodule
`default_nettype wire
